// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths and the response-owner tag
// used by the memory port arbiter.
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 64;

  // Width of the fetch starvation counter (holds up to 15).
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the
// load/store path. Load/store wins conflicts unless fetch has lost
// STARVE_MAX conflicts in a row. Read data returns to the issuing port one
// cycle after its grant; the idle port's read data holds its last value.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    rsp_pending;
  owner_e                  rsp_owner;
  logic [DATA_W-1:0]       f_rdata_q;
  logic [DATA_W-1:0]       d_rdata_q;
  logic                    fetch_starved;

  // Saturating increment of the starvation counter.
  function automatic logic [STARVE_CNT_W-1:0] sat_inc(
    input logic [STARVE_CNT_W-1:0] cnt
  );
    if (cnt >= STARVE_LIM) begin
      return STARVE_LIM;
    end
    return cnt + 1'b1;
  endfunction

  assign fetch_starved = (starve_cnt == STARVE_LIM);

  // Grant decision: data has priority unless fetch has been starved.
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (d_req && !(f_req && fetch_starved)) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  // Memory command mux from the winning requester; fetch never writes.
  always_comb begin
    mem_en    = f_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (f_gnt) begin
      mem_addr = f_addr;
    end
  end

  // Starvation counter: counts data wins while fetch is waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (f_gnt || !f_req) begin
      starve_cnt <= '0;
    end else if (d_gnt) begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Response tracker: remembers whether the issued access was a read and who owns it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_pending <= 1'b0;
      rsp_owner   <= OWN_F;
    end else begin
      rsp_pending <= f_gnt | (d_gnt & ~d_we);
      rsp_owner   <= d_gnt ? OWN_D : OWN_F;
    end
  end

  // A pending response is dropped while reset is high.
  assign f_rvalid = rsp_pending && (rsp_owner == OWN_F) && !reset;
  assign d_rvalid = rsp_pending && (rsp_owner == OWN_D) && !reset;

  // Hold the last delivered read data for each port.
  always_ff @(posedge clock) begin
    if (reset) begin
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (f_rvalid) f_rdata_q <= mem_rdata;
      if (d_rvalid) d_rdata_q <= mem_rdata;
    end
  end

  assign f_rdata = f_rvalid ? mem_rdata : f_rdata_q;
  assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM model, a transaction-level reference
// model checked every cycle, and directed scenarios with literal checks.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 64;
  localparam int SMAX = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] f_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // ---------------- RAM model (the environment) ----------------
  logic [DW-1:0] ram [int];

  function automatic logic [DW-1:0] ram_fill(input logic [AW-1:0] a);
    return {16'hC0DE, a, ~a, a};
  endfunction

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : ram_fill(mem_addr);
    end
  end

  // ---------------- Reference model ----------------
  logic [DW-1:0] shadow [int];
  int            m_wait = 0;        // data wins in a row while fetch waits
  bit            m_pend = 0;        // a read response is due next cycle
  bit            m_pend_d = 0;      // response belongs to the data port
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] m_last_f = '0;
  logic [DW-1:0] m_last_d = '0;

  function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : {16'hC0DE, a, ~a, a};
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    ram[int'(a)] = v;
    shadow[int'(a)] = v;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clock) begin
    bit            e_f, e_d, e_frv, e_drv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_frd, e_drd;
    e_f = 0; e_d = 0;
    if (!reset) begin
      if (d_req && f_req) begin
        if (m_wait >= SMAX) e_f = 1; else e_d = 1;
      end else if (d_req) e_d = 1;
      else if (f_req) e_f = 1;
    end
    e_addr  = e_d ? d_addr : (e_f ? f_addr : '0);
    e_wdata = e_d ? d_wdata : '0;
    e_frv   = !reset && m_pend && !m_pend_d;
    e_drv   = !reset && m_pend && m_pend_d;
    e_frd   = e_frv ? m_pend_data : m_last_f;
    e_drd   = e_drv ? m_pend_data : m_last_d;

    chk("f_gnt", DW'(f_gnt), DW'(e_f));
    chk("d_gnt", DW'(d_gnt), DW'(e_d));
    chk("mem_en", DW'(mem_en), DW'(e_f | e_d));
    chk("mem_we", DW'(mem_we), DW'(e_d & d_we));
    chk("mem_addr", DW'(mem_addr), DW'(e_addr));
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("f_rvalid", DW'(f_rvalid), DW'(e_frv));
    chk("d_rvalid", DW'(d_rvalid), DW'(e_drv));
    chk("f_rdata", f_rdata, e_frd);
    chk("d_rdata", d_rdata, e_drd);

    if (reset) begin
      m_wait = 0; m_pend = 0; m_pend_d = 0; m_last_f = '0; m_last_d = '0;
    end else begin
      if (e_frv) m_last_f = m_pend_data;
      if (e_drv) m_last_d = m_pend_data;
      m_pend = 0;
      if (e_d) begin
        if (d_we) shadow[int'(d_addr)] = d_wdata;
        else begin
          m_pend = 1; m_pend_d = 1; m_pend_data = sh_rd(d_addr);
        end
        m_wait = f_req ? ((m_wait + 1 > SMAX) ? SMAX : m_wait + 1) : 0;
      end else if (e_f) begin
        m_pend = 1; m_pend_d = 0; m_pend_data = sh_rd(f_addr);
        m_wait = 0;
      end else begin
        m_wait = 0;
      end
    end
  end

  // ---------------- Directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    string got;
    preload(16'h0004, 64'h1122334455667788);
    preload(16'h0001, 64'h0101010101010101);
    preload(16'h0002, 64'h0202020202020202);

    reset = 1; f_req = 1; d_req = 1; d_we = 0;
    f_addr = 16'h0100; d_addr = 16'h0200; d_wdata = '0;

    // Reset with both requests high
    mid();
    chk("rst_f_gnt", DW'(f_gnt), '0);
    chk("rst_d_gnt", DW'(d_gnt), '0);
    chk("rst_mem_en", DW'(mem_en), '0);
    chk("rst_f_rdata", f_rdata, '0);
    chk("rst_d_rvalid", DW'(d_rvalid), '0);
    step();
    mid();
    chk("rst_mem_en2", DW'(mem_en), '0);
    step();
    reset = 0; f_req = 0; d_req = 0;
    step();

    // Lone fetch
    f_req = 1; f_addr = 16'h0004;
    mid();
    chk("fetch_gnt", DW'(f_gnt), 64'd1);
    step();
    f_req = 0;
    mid();
    chk("fetch_rvalid", DW'(f_rvalid), 64'd1);
    chk("fetch_rdata", f_rdata, 64'h1122334455667788);
    step();

    // Store then load same address
    d_req = 1; d_we = 1; d_addr = 16'h0010; d_wdata = 64'hDEADBEEF00000001;
    mid();
    chk("store_gnt", DW'(d_gnt), 64'd1);
    chk("store_mem_we", DW'(mem_we), 64'd1);
    step();
    d_we = 0; d_wdata = '0;
    mid();
    chk("store_no_rvalid", DW'(d_rvalid), '0);
    step();
    d_req = 0;
    mid();
    chk("load_rvalid", DW'(d_rvalid), 64'd1);
    chk("load_rdata", d_rdata, 64'hDEADBEEF00000001);
    step();

    // Contention: both held for 10 cycles
    f_req = 1; f_addr = 16'h0020; d_req = 1; d_we = 0; d_addr = 16'h0030;
    got = "";
    for (int i = 0; i < 10; i++) begin
      mid();
      got = {got, d_gnt ? "D" : (f_gnt ? "F" : "-")};
      step();
    end
    n_vec++;
    if (got != "DDDDFDDDDF") begin
      n_err++;
      $display("FAIL contention_pattern: got %s expected DDDDFDDDDF", got);
    end
    f_req = 0; d_req = 0;
    step();

    // Interleaved fetch 0x0001 / load 0x0002
    for (int i = 0; i < 3; i++) begin
      f_req = 1; f_addr = 16'h0001; d_req = 0;
      step();
      f_req = 0; d_req = 1; d_we = 0; d_addr = 16'h0002;
      if (i == 0) begin
        mid();
        chk("ilv_f_rvalid", DW'(f_rvalid), 64'd1);
        chk("ilv_f_rdata", f_rdata, 64'h0101010101010101);
        chk("ilv_d_gnt", DW'(d_gnt), 64'd1);
      end
      step();
    end
    d_req = 0;
    mid();
    chk("ilv_d_rdata", d_rdata, 64'h0202020202020202);
    chk("ilv_f_hold", f_rdata, 64'h0101010101010101);
    step();

    // Store with fetch waiting, then fetch reads it back
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 64'h0123456789ABCDEF;
    f_req = 1; f_addr = 16'h0040;
    step();
    d_req = 0; d_we = 0;
    step();
    f_req = 0;
    mid();
    chk("fetch_after_store", f_rdata, 64'h0123456789ABCDEF);
    step();

    // Reset the cycle after a load grant
    d_req = 1; d_we = 0; d_addr = 16'h0002;
    step();
    reset = 1; d_req = 0;
    mid();
    chk("rstmid_rvalid_n1", DW'(d_rvalid), '0);
    step();
    reset = 0;
    mid();
    chk("rstmid_rvalid_n2", DW'(d_rvalid), '0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
